// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory: data accesses win by default,
// a starvation counter forces fetch through, and an in-order tag queue routes responses.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output logic                err_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUT);
  localparam logic [SC_W-1:0]  STARVE_MX = SC_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_OUT - 1);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [SC_W-1:0]  starve_reg, starve_next;
  logic [MAX_OUT-1:0] tag_reg;
  logic             err_reg, err_next;

  logic sel_if, starved, not_full, not_empty, head_tag, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign starved   = (starve_reg == STARVE_MX);
  assign sel_if    = if_req_i & (~dm_req_i | starved);
  assign not_full  = (count_reg != FULL_CNT);
  assign not_empty = (count_reg != '0);
  assign head_tag  = tag_reg[rd_ptr_reg];

  // Reset gates the request so no grant can push a tag during a reset cycle.
  assign mem_req_o   = (if_req_i | dm_req_i) & not_full & resetn;
  assign mem_addr_o  = sel_if ? if_addr_i : dm_addr_i;
  assign mem_we_o    = ~sel_if & dm_we_i;
  assign mem_be_o    = sel_if ? '1 : dm_be_i;
  assign mem_wdata_o = sel_if ? '0 : dm_wdata_i;

  assign if_gnt_o = mem_req_o & mem_gnt_i & sel_if;
  assign dm_gnt_o = mem_req_o & mem_gnt_i & ~sel_if;

  assign push = if_gnt_o | dm_gnt_o;
  assign pop  = mem_rvalid_i & not_empty & resetn;

  assign if_rvalid_o = pop & ~head_tag;
  assign dm_rvalid_o = pop & head_tag;
  assign if_rdata_o  = mem_rdata_i;
  assign dm_rdata_o  = mem_rdata_i;

  assign busy_o = not_empty;
  assign err_o  = err_reg;

  always_comb begin
    count_next  = count_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    starve_next = starve_reg;
    err_next    = err_reg;
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // Holding (not clearing) while the memory stalls keeps the fairness credit.
    if (!if_req_i || if_gnt_o)
      starve_next = '0;
    else if (dm_gnt_o && !starved)
      starve_next = starve_reg + 1'b1;
    if (mem_rvalid_i && !not_empty)
      err_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      starve_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      starve_reg <= starve_next;
      err_reg    <= err_next;
    end
  end

  // Tag 1 marks a data-side transaction, 0 a fetch.
  for (genvar gi = 0; gi < MAX_OUT; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (!resetn)
        tag_reg[gi] <= 1'b0;
      else if (push && wr_ptr_reg == PTR_W'(gi))
        tag_reg[gi] <= ~sel_if;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: expected responses queued at grant, checked at rvalid.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [3:0]  dm_be_i = '0;
  logic [31:0] dm_addr_i = '0, dm_wdata_i = '0;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o, err_o;

  typedef struct packed { logic tag; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic idle_inputs();
    if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  // Pops the scoreboard head, drives it as the memory response, and checks the routing.
  task automatic respond(input string name);
    e = sb.pop_front();
    mem_rvalid_i = 1; mem_rdata_i = e.data;
    #1;
    n_checks++;
    if (if_rvalid_o !== ~e.tag || dm_rvalid_o !== e.tag)
      $display("FAIL %s_route: if_rvalid=%b dm_rvalid=%b want tag %0d", name, if_rvalid_o, dm_rvalid_o, e.tag);
    else n_pass++;
    n_checks++;
    if ((e.tag ? dm_rdata_o : if_rdata_o) !== e.data)
      $display("FAIL %s_rdata: got %h want %h", name, e.tag ? dm_rdata_o : if_rdata_o, e.data);
    else n_pass++;
    $display("resp %s owner=%s data=%h", name, e.tag ? "DM" : "IF", e.data);
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 0; if_req_i = 1; dm_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    #1;
    n_checks++;
    if ({mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o} !== 5'b0)
      $display("FAIL reset_outs: got %b want 00000", {mem_req_o, if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o});
    else n_pass++;
    @(negedge clk);
    resetn = 1; idle_inputs();
    #1;
    n_checks++;
    if ({busy_o, err_o} !== 2'b00) $display("FAIL reset_state: busy/err=%b want 00", {busy_o, err_o});
    else n_pass++;
    $display("txn reset done");
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    if_req_i = 1; if_addr_i = 32'h8000_0000; mem_gnt_i = 1;
    #1;
    n_checks++;
    if ({if_gnt_o, dm_gnt_o, mem_we_o, mem_be_o} !== 7'b1001111 || mem_addr_o !== 32'h8000_0000)
      $display("FAIL fetch_gnt: gnt=%b%b we=%b be=%h addr=%h want 10 0 f 80000000",
               if_gnt_o, dm_gnt_o, mem_we_o, mem_be_o, mem_addr_o);
    else n_pass++;
    sb.push_back('{tag: 1'b0, data: 32'h0000_0013});
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL fetch_busy: got %b want 1", busy_o); else n_pass++;
    respond("fetch");
    @(negedge clk);
    mem_rvalid_i = 0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL fetch_idle: busy=%b want 0", busy_o); else n_pass++;
  endtask

  // Both requesters held: DM x4, IF, DM; memory answers every grant one cycle later.
  task automatic test_starvation(input string name);
    logic exp_if;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      mem_rvalid_i = 0;
      if (k < 6) begin
        if_req_i = 1; if_addr_i = 32'h100 + 32'(4 * k);
        dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011;
        dm_addr_i = 32'h2000 + 32'(4 * k); dm_wdata_i = 32'hDEAD_BEEF;
        mem_gnt_i = 1;
      end else idle_inputs();
      if (sb.size() != 0) respond(name);
      #1;
      if (k < 6) begin
        exp_if = (k == 4);
        n_checks++;
        if ({if_gnt_o, dm_gnt_o} !== {exp_if, ~exp_if})
          $display("FAIL %s_gnt%0d: if/dm=%b%b want %b%b", name, k, if_gnt_o, dm_gnt_o, exp_if, ~exp_if);
        else n_pass++;
        n_checks++;
        if (mem_we_o !== ~exp_if || mem_wdata_o !== (exp_if ? 32'h0 : 32'hDEAD_BEEF) ||
            mem_be_o !== (exp_if ? 4'hf : 4'h3) ||
            mem_addr_o !== (exp_if ? 32'h100 + 32'(4 * k) : 32'h2000 + 32'(4 * k)))
          $display("FAIL %s_mux%0d: we=%b be=%h addr=%h wdata=%h", name, k, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        else n_pass++;
        sb.push_back('{tag: ~exp_if, data: 32'h5000 + 32'(k)});
      end
    end
    @(negedge clk);
    mem_rvalid_i = 0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL %s_drain: busy=%b want 0", name, busy_o); else n_pass++;
  endtask

  task automatic test_full_queue();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hf; dm_addr_i = 32'h3000 + 32'(4 * k); mem_gnt_i = 1;
      #1;
      n_checks++;
      if ({mem_req_o, dm_gnt_o} !== ((k < 2) ? 2'b11 : 2'b00))
        $display("FAIL full_req%0d: req/gnt=%b%b want %b", k, mem_req_o, dm_gnt_o, (k < 2) ? 2'b11 : 2'b00);
      else n_pass++;
      if (k < 2) sb.push_back('{tag: 1'b1, data: 32'hF000 + 32'(k)});
    end
    n_checks++;
    if (busy_o !== 1'b1) $display("FAIL full_busy: got %b want 1", busy_o); else n_pass++;
    @(negedge clk);
    respond("full");
    n_checks++;
    if (mem_req_o !== 1'b0) $display("FAIL full_popgate: mem_req=%b want 0", mem_req_o); else n_pass++;
    @(negedge clk);
    mem_rvalid_i = 0;
    #1;
    n_checks++;
    if ({mem_req_o, dm_gnt_o} !== 2'b11) $display("FAIL full_reopen: req/gnt=%b%b want 11", mem_req_o, dm_gnt_o);
    else n_pass++;
    sb.push_back('{tag: 1'b1, data: 32'hF002});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle_inputs();
      respond("full_drain");
    end
    @(negedge clk);
    mem_rvalid_i = 0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL full_empty: busy=%b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_ordering();
    @(negedge clk);
    if_req_i = 1; mem_gnt_i = 1;
    #1;
    n_checks++;
    if (if_gnt_o !== 1'b1) $display("FAIL order_ifgnt: got %b want 1", if_gnt_o); else n_pass++;
    sb.push_back('{tag: 1'b0, data: 32'hAAAA_0000});
    @(negedge clk);
    if_req_i = 0; dm_req_i = 1; dm_we_i = 0;
    #1;
    n_checks++;
    if (dm_gnt_o !== 1'b1) $display("FAIL order_dmgnt: got %b want 1", dm_gnt_o); else n_pass++;
    sb.push_back('{tag: 1'b1, data: 32'h5555_FFFF});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      idle_inputs();
      respond("order");
    end
    @(negedge clk);
    mem_rvalid_i = 0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL order_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_spurious();
    @(negedge clk);
    mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
    #1;
    n_checks++;
    if ({if_rvalid_o, dm_rvalid_o, err_o} !== 3'b000)
      $display("FAIL spur_same: rv/rv/err=%b want 000", {if_rvalid_o, dm_rvalid_o, err_o});
    else n_pass++;
    $display("txn spurious response driven");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rvalid_i = 0;
      #1;
      n_checks++;
      if (err_o !== 1'b1) $display("FAIL spur_err%0d: got %b want 1", k, err_o); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rvalid_i = 0;
      if_req_i = 1; dm_req_i = 1; dm_we_i = 0; mem_gnt_i = 1;
      if (sb.size() != 0) respond("pre_rst");
      #1;
      n_checks++;
      if (dm_gnt_o !== 1'b1) $display("FAIL pre_rst_gnt%0d: got %b want 1", k, dm_gnt_o); else n_pass++;
      sb.push_back('{tag: 1'b1, data: 32'h7000 + 32'(k)});
    end
    @(negedge clk);
    resetn = 0; mem_rvalid_i = 0;
    #1;
    n_checks++;
    if ({mem_req_o, if_gnt_o, dm_gnt_o} !== 3'b000)
      $display("FAIL mid_rst_req: req/gnt=%b want 000", {mem_req_o, if_gnt_o, dm_gnt_o});
    else n_pass++;
    sb.delete();
    @(negedge clk);
    resetn = 1; idle_inputs();
    #1;
    n_checks++;
    if ({busy_o, err_o} !== 2'b00) $display("FAIL mid_rst_state: busy/err=%b want 00", {busy_o, err_o});
    else n_pass++;
    $display("txn reset mid-operation done");
    test_starvation("post_rst");
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_starvation("starve");
    test_full_queue();
    test_ordering();
    test_spurious();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
